sub_serial: RTL and testbench
=============================

Name: sub_serial

Overview:
Bit-serial, LSB-first multi-cycle subtractor. It computes z = x - y - bi with one full-subtractor step per clock, and is the inverse-operation counterpart of the team's ripple adders. A start/ready/done handshake lets a controller issue operations back-to-back. It reports borrow-out and signed overflow.

Parameters:
W, 8, operand and result width in bits (W >= 2).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new operation; sampled only when ready=1.
x  input  W  minuend; captured on the accept edge.
y  input  W  subtrahend; captured on the accept edge.
bi  input  1  borrow-in; captured on the accept edge.
ready  output  1  block can accept start this cycle.
done  output  1  one-cycle pulse: result valid.
z  output  W  difference x - y - bi, mod 2^W.
bo  output  1  borrow-out; 1 when unsigned x < y + bi.
ovf  output  1  two's-complement overflow of the subtraction.

Behaviour:
- Reset: rst=1 at a rising edge forces state IDLE. It also clears z=0, bo=0, ovf=0, done=0 and all internal shift registers and counters.
- ready=1 after reset. ready=1 in states IDLE and DONE, and 0 in BUSY.
- Reset is honoured in every state, including mid-operation. A partial result is discarded, never reported.
- States are IDLE, BUSY and DONE.
- IDLE → BUSY: on an edge with start=1. At that edge:
  - latch x into xs and y into ys;
  - latch x[W-1] and y[W-1] as sign copies;
  - borrow register b = bi;
  - bit counter cnt = 0;
  - clear the result shift register.
- BUSY, each edge:
  - d = xs[0] ^ ys[0] ^ b;
  - b_next = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);
  - result shift register shifts right with d entering at bit W-1;
  - xs and ys shift right by 1;
  - cnt increments.
- BUSY → DONE: on the edge where cnt reaches W-1, i.e. the W-th BUSY edge. At that edge:
  - z takes the final shifted result;
  - bo = b_next;
  - ovf = (xsign != ysign) & (z[W-1] != xsign).
- DONE lasts exactly one cycle with done=1.
  - On the next edge, if start=1, a new operation is accepted (DONE → BUSY, same capture as from IDLE).
  - Otherwise the state returns to IDLE.
- Latency: if start is accepted at edge k, done=1 in the cycle following edge k+W. That is W+1 edges from accept to the done pulse, counting the DONE exit edge.
- Throughput: one result per W+1 cycles.
- z, bo and ovf change only on the BUSY → DONE edge or on reset. They hold their value through IDLE until the next result.
- start while in BUSY is ignored: no restart, no queuing, and the operation in flight is unaffected.
- x, y and bi may change freely after the accept edge; only the captured values are used.
- Arithmetic is mod 2^W with no saturation. bo reflects the unsigned interpretation; ovf reflects the signed interpretation.
- Simultaneous rst=1 and start=1: reset wins, and the block stays in IDLE.

Test Plan:
- W=8, x=100, y=58, bi=0, start pulse → done exactly W+1 edges later, z=42, bo=0, ovf=0; ready=0 throughout BUSY.
- W=8, x=0, y=1, bi=0 → z=8'hFF, bo=1, ovf=0.
- W=8, x=8'h80, y=8'h01, bi=0 → z=8'h7F, bo=0, ovf=1.
- W=8, x=5, y=5, bi=1 → z=8'hFF, bo=1.
- Back-to-back operations:
  - hold start=1 continuously, with x=3, y=1 then x=9, y=4;
  - required: two done pulses W+1 cycles apart, z=2 then z=5;
  - a start pulse injected mid-BUSY changes nothing.
- Reset cases:
  - assert rst at the 3rd BUSY edge → no done, z=0, ready=1 next cycle;
  - then W=2 exhaustive over {x,y,bi} = 0..31, each result compared with (x - y - bi) mod 4 and its borrow.

Source files
------------

// File: rtl/sub_serial_if.sv
// Operand/result bundle for the bit-serial subtractor: the controller (master)
// issues start with x/y/bi, the subtractor (slave) answers with ready/done/z/bo/ovf.
interface sub_serial_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bi;
    logic         ready;
    logic         done;
    logic [W-1:0] z;
    logic         bo;
    logic         ovf;

    modport master (
        output start, x, y, bi,
        input  ready, done, z, bo, ovf
    );

    modport slave (
        input  start, x, y, bi,
        output ready, done, z, bo, ovf
    );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial LSB-first subtractor z = x - y - bi, one full-subtractor step per
// clock, with borrow-out and signed-overflow flags and a start/ready/done handshake.
module sub_serial #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    sub_serial_if.slave  bus
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_reg;
    logic [W-1:0]  xs_reg;
    logic [W-1:0]  ys_reg;
    logic [W-1:0]  res_reg;
    logic [CW-1:0] cnt_reg;
    logic          b_reg;
    logic          xsign_reg;
    logic          ysign_reg;
    logic          ready_reg;
    logic          done_reg;
    logic [W-1:0]  z_reg;
    logic          bo_reg;
    logic          ovf_reg;

    logic          d_next;
    logic          b_next;
    logic [W-1:0]  res_next;
    logic          accept;

    // One full-subtractor slice on the current LSBs.
    always_comb begin
        d_next   = xs_reg[0] ^ ys_reg[0] ^ b_reg;
        b_next   = (~xs_reg[0] & ys_reg[0]) | (~(xs_reg[0] ^ ys_reg[0]) & b_reg);
        res_next = {d_next, res_reg[W-1:1]};
        accept   = bus.start && (state_reg != BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            xs_reg    <= '0;
            ys_reg    <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            b_reg     <= 1'b0;
            xsign_reg <= 1'b0;
            ysign_reg <= 1'b0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
            z_reg     <= '0;
            bo_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            // Same capture whether coming from IDLE or straight out of DONE.
            state_reg <= BUSY;
            xs_reg    <= bus.x;
            ys_reg    <= bus.y;
            xsign_reg <= bus.x[W-1];
            ysign_reg <= bus.y[W-1];
            b_reg     <= bus.bi;
            cnt_reg   <= '0;
            res_reg   <= '0;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                BUSY: begin
                    xs_reg  <= xs_reg >> 1;
                    ys_reg  <= ys_reg >> 1;
                    res_reg <= res_next;
                    b_reg   <= b_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        state_reg <= DONE;
                        ready_reg <= 1'b1;
                        done_reg  <= 1'b1;
                        z_reg     <= res_next;
                        bo_reg    <= b_next;
                        ovf_reg   <= (xsign_reg != ysign_reg) && (d_next != xsign_reg);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_reg;
    assign bus.done  = done_reg;
    assign bus.z     = z_reg;
    assign bus.bo    = bo_reg;
    assign bus.ovf   = ovf_reg;
endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial at W=8 and W=2: a behavioural model predicts the
// handshake each cycle and a scoreboard holds expected results until done.
module tb_sub_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sub_serial_if #(.W(8)) bus8();
    sub_serial_if #(.W(2)) bus2();

    sub_serial #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    sub_serial #(.W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct packed {
        logic [7:0]  z;
        logic        bo;
        logic        ovf;
        logic [31:0] due;
    } res_t;

    res_t q8[$];
    res_t q2[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_state [2];
    int   m_cnt   [2];
    res_t m_pend  [2];
    res_t m_out   [2];

    task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d cyc=%0d: got %0h want %0h", tag, d, cyc, obs, exp);
        end
    endtask

    function automatic res_t calc(int w, logic [7:0] x, logic [7:0] y, logic bi);
        res_t r;
        int xi, yi, diff;
        logic [7:0] mask;
        xi   = x;
        yi   = y;
        diff = xi - yi - (bi ? 1 : 0);
        mask = 8'((1 << w) - 1);
        r     = '0;
        r.z   = diff[7:0] & mask;
        r.bo  = (diff < 0);
        r.ovf = (x[w-1] != y[w-1]) && (r.z[w-1] != x[w-1]);
        return r;
    endfunction

    // Advance the model across the coming edge using the inputs now applied.
    task automatic model_edge(int d, int w, logic st, logic [7:0] x, logic [7:0] y, logic bi);
        if (rst) begin
            m_state[d] = 0;
            m_cnt[d]   = 0;
            m_out[d]   = '0;
            if (d == 0) q8.delete(); else q2.delete();
        end else if (m_state[d] != 1 && st) begin
            m_state[d]    = 1;
            m_cnt[d]      = 0;
            m_pend[d]     = calc(w, x, y, bi);
            m_pend[d].due = cyc + 1 + w;
            if (d == 0) q8.push_back(m_pend[d]); else q2.push_back(m_pend[d]);
        end else if (m_state[d] == 1) begin
            if (m_cnt[d] == w - 1) begin
                m_state[d] = 2;
                m_out[d]   = m_pend[d];
            end
            m_cnt[d]++;
        end else if (m_state[d] == 2) begin
            m_state[d] = 0;
        end
    endtask

    task automatic check_outs(int d, logic rdy, logic dn, logic [7:0] z, logic bo, logic ovf);
        res_t e;
        chk("ready", d, 32'(rdy), 32'(m_state[d] != 1));
        chk("done",  d, 32'(dn),  32'(m_state[d] == 2));
        chk("z_hold", d, 32'(z),  32'(m_out[d].z));
        chk("bo_hold", d, 32'(bo), 32'(m_out[d].bo));
        chk("ovf_hold", d, 32'(ovf), 32'(m_out[d].ovf));
        if (dn === 1'b1) begin
            if ((d == 0 && q8.size() == 0) || (d == 1 && q2.size() == 0)) begin
                chk("sb_empty", d, 32'd0, 32'd1);
            end else begin
                e = (d == 0) ? q8.pop_front() : q2.pop_front();
                chk("sb_z",    d, 32'(z),   32'(e.z));
                chk("sb_bo",   d, 32'(bo),  32'(e.bo));
                chk("sb_ovf",  d, 32'(ovf), 32'(e.ovf));
                chk("latency", d, 32'(cyc), e.due);
            end
        end
    endtask

    task automatic tick();
        model_edge(0, 8, bus8.start, bus8.x, bus8.y, bus8.bi);
        model_edge(1, 2, bus2.start, {6'b0, bus2.x}, {6'b0, bus2.y}, bus2.bi);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outs(0, bus8.ready, bus8.done, bus8.z, bus8.bo, bus8.ovf);
        check_outs(1, bus2.ready, bus2.done, {6'b0, bus2.z}, bus2.bo, bus2.ovf);
    endtask

    task automatic op8(logic [7:0] x, logic [7:0] y, logic bi);
        bus8.x = x; bus8.y = y; bus8.bi = bi; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.x = 8'($urandom); bus8.y = 8'($urandom); bus8.bi = 1'($urandom);
        repeat (9) tick();
        $display("op8 x=%0h y=%0h bi=%0b -> z=%0h bo=%0b ovf=%0b", x, y, bi, bus8.z, bus8.bo, bus8.ovf);
    endtask

    initial begin
        logic [4:0] v;
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; m_cnt[d] = 0; m_pend[d] = '0; m_out[d] = '0;
        end
        bus8.start = 1'b0; bus8.x = '0; bus8.y = '0; bus8.bi = 1'b0;
        bus2.start = 1'b0; bus2.x = '0; bus2.y = '0; bus2.bi = 1'b0;

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // 100 - 58 with a stray start injected mid-operation.
        bus8.x = 8'd100; bus8.y = 8'd58; bus8.bi = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (3) tick();
        bus8.x = 8'd7; bus8.y = 8'd200; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (5) tick();
        $display("op8 x=64 y=3a bi=0 -> z=%0h bo=%0b ovf=%0b", bus8.z, bus8.bo, bus8.ovf);

        op8(8'h00, 8'h01, 1'b0);
        op8(8'h80, 8'h01, 1'b0);
        op8(8'd5,  8'd5,  1'b1);
        op8(8'h7F, 8'hFF, 1'b0);

        // Back-to-back with start held high.
        bus8.x = 8'd3; bus8.y = 8'd1; bus8.bi = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.x = 8'd9; bus8.y = 8'd4;
        repeat (9) tick();
        bus8.start = 1'b0;
        repeat (9) tick();
        $display("b2b second -> z=%0h bo=%0b", bus8.z, bus8.bo);

        // Reset on the third BUSY edge discards the operation.
        bus8.x = 8'd50; bus8.y = 8'd20; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        $display("mid-busy reset -> z=%0h ready=%0b", bus8.z, bus8.ready);

        // Reset and start together: reset wins.
        bus8.x = 8'd1; bus8.y = 8'd0; bus8.start = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; bus8.start = 1'b0;
        repeat (2) tick();
        $display("rst+start -> ready=%0b done=%0b", bus8.ready, bus8.done);

        // W=2 exhaustive, issued back-to-back out of DONE.
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            bus2.x = v[4:3]; bus2.y = v[2:1]; bus2.bi = v[0]; bus2.start = 1'b1;
            tick();
            bus2.start = 1'b0;
            repeat (2) tick();
            $display("op2 x=%0d y=%0d bi=%0b -> z=%0d bo=%0b", v[4:3], v[2:1], v[0], bus2.z, bus2.bo);
        end
        repeat (4) tick();

        chk("sb_drain8", 0, 32'(q8.size()), 32'd0);
        chk("sb_drain2", 1, 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
